// File: rtl/uart_rx.sv
// Oversampling UART receiver: 3-sample majority per bit, optional even/odd parity,
// registered P_DATA with a one-cycle data_valid pulse per good frame.
module uart_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      parity_enable,
  input  logic                      parity_type,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid
);

  localparam int PW    = PRESCALE_WIDTH;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           edge_cnt_q, edge_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]              samp_q, samp_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    par_err_q, par_err_d;
  logic                    par_en_q, par_en_d;
  logic                    par_type_q, par_type_d;
  logic                    wait_high_q, wait_high_d;
  logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
  logic                    valid_q, valid_d;

  logic [PW-1:0]    half, samp_a, samp_c;
  logic             last_edge, at_samp_c, bit_val;
  logic [BIT_W-1:0] last_bit;

  assign half      = Prescale >> 1;
  assign samp_a    = half - PW'(1);
  assign samp_c    = half + PW'(1);
  assign last_edge = (edge_cnt_q == Prescale - PW'(1));
  assign at_samp_c = (edge_cnt_q == samp_c);
  assign last_bit  = BIT_W'(DATA_WIDTH - 1);
  // Third sample is the live line value; the first two were captured on earlier edges.
  assign bit_val   = (samp_q[0] & samp_q[1]) | (samp_q[0] & RX_IN) | (samp_q[1] & RX_IN);

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (!wait_high_q && !RX_IN) state_d = START;
      START: begin
        if (at_samp_c && bit_val) state_d = IDLE;
        else if (last_edge)       state_d = DATA;
      end
      DATA:   if (last_edge && bit_cnt_q == last_bit) state_d = par_en_q ? PARITY : STOP;
      PARITY: if (last_edge) state_d = STOP;
      STOP:   if (at_samp_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every signal gets a hold default before the case so no path infers a latch.
  always_comb begin
    edge_cnt_d  = edge_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    samp_d      = samp_q;
    data_d      = data_q;
    par_err_d   = par_err_q;
    par_en_d    = par_en_q;
    par_type_d  = par_type_q;
    wait_high_d = wait_high_q;
    p_data_d    = p_data_q;
    valid_d     = 1'b0;

    if (state_q == IDLE) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
      if (wait_high_q && RX_IN) wait_high_d = 1'b0;
      // The detecting edge is edge 0 of the start bit, so counting resumes at 1.
      if (state_d == START) begin
        edge_cnt_d = PW'(1);
        par_en_d   = parity_enable;
        par_type_d = parity_type;
        par_err_d  = 1'b0;
      end
    end else begin
      edge_cnt_d = last_edge ? '0 : edge_cnt_q + PW'(1);
      if (edge_cnt_q == samp_a) samp_d[0] = RX_IN;
      if (edge_cnt_q == half)   samp_d[1] = RX_IN;
    end

    unique case (state_q)
      DATA: begin
        if (at_samp_c) data_d[bit_cnt_q] = bit_val;
        if (last_edge) bit_cnt_d = (bit_cnt_q == last_bit) ? '0 : bit_cnt_q + BIT_W'(1);
      end
      PARITY: if (at_samp_c) par_err_d = (bit_val != ((^data_q) ^ par_type_q));
      STOP: begin
        if (at_samp_c) begin
          if (bit_val && !par_err_q) begin
            p_data_d = data_q;
            valid_d  = 1'b1;
          end else if (!bit_val) begin
            // A line still held low must go high before a new start is accepted.
            wait_high_d = !RX_IN;
          end
        end
      end
      default: ;
    endcase

    if (state_q != IDLE && state_d == IDLE) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      samp_q      <= '0;
      data_q      <= '0;
      par_err_q   <= 1'b0;
      par_en_q    <= 1'b0;
      par_type_q  <= 1'b0;
      wait_high_q <= 1'b0;
      p_data_q    <= '0;
      valid_q     <= 1'b0;
    end else begin
      edge_cnt_q  <= edge_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      samp_q      <= samp_d;
      data_q      <= data_d;
      par_err_q   <= par_err_d;
      par_en_q    <= par_en_d;
      par_type_q  <= par_type_d;
      wait_high_q <= wait_high_d;
      p_data_q    <= p_data_d;
      valid_q     <= valid_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = valid_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames plus randomized frames with
// parity/stop errors and start glitches, checked against a frame-level model.
module tb_uart_rx;

  localparam int DW = 8;
  localparam int PW = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic [PW-1:0] Prescale;
  logic          parity_enable;
  logic          parity_type;
  logic [DW-1:0] P_DATA;
  logic          data_valid;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_pdata;

  uart_rx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
    .parity_enable(parity_enable), .parity_type(parity_type),
    .P_DATA(P_DATA), .data_valid(data_valid)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every data_valid pulse must match the oldest expected byte and last one cycle.
  always begin
    @(negedge CLK);
    if (data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {24'd0, P_DATA}, 32'hFFFF_FFFF);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        check("rx_byte", {24'd0, P_DATA}, {24'd0, e});
      end
      @(negedge CLK);
      check("valid_width", {31'd0, data_valid}, 32'd0);
    end
  end

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Builds the frame from the line rules, pushes the expectation if it is a good frame,
  // then drives each bit for p clocks. scramble changes the parity controls mid-frame.
  task automatic send_frame(input logic [DW-1:0] d, input int p, input bit pen, input bit ptype,
                            input bit par_flip, input bit stop_val, input bit scramble);
    bit bits[$];
    Prescale      = PW'(p);
    parity_enable = pen;
    parity_type   = ptype;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pen) bits.push_back((^d) ^ ptype ^ par_flip);
    bits.push_back(stop_val);
    if (stop_val && !(pen && par_flip)) begin
      exp_q.push_back(d);
      model_pdata = d;
    end
    foreach (bits[i]) begin
      RX_IN = bits[i];
      if (scramble && i == 1) begin
        parity_enable = 1'($urandom);
        parity_type   = 1'($urandom);
      end
      repeat (p) @(posedge CLK);
      #1;
    end
    RX_IN = 1'b1;
    check("hold_pdata", {24'd0, P_DATA}, {24'd0, model_pdata});
  endtask

  task automatic glitch(input int p, input int len);
    Prescale = PW'(p);
    RX_IN    = 1'b0;
    repeat (len) @(posedge CLK);
    #1;
    idle(p + 2);
  endtask

  initial begin
    RX_IN         = 1'b1;
    Prescale      = PW'(8);
    parity_enable = 1'b0;
    parity_type   = 1'b0;
    model_pdata   = '0;
    RST           = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_pdata", {24'd0, P_DATA}, 32'd0);
    check("reset_valid", {31'd0, data_valid}, 32'd0);
    RST = 1'b0;
    idle(4);

    // Back-to-back even-parity frames.
    send_frame(8'h55, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h7D, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    // Bad parity then good frame.
    send_frame(8'h55, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    // Stop error with line held low, then recovery.
    send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    // Two-clock start glitch.
    glitch(8, 2);
    idle(4);
    send_frame(8'h81, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    // No parity at Prescale 16; odd parity at Prescale 8.
    send_frame(8'hA3, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h01, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Reset in the middle of data bit 4 of 0xFF.
    Prescale      = PW'(8);
    parity_enable = 1'b0;
    RX_IN         = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    repeat (8 * 4 + 4) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("midreset_pdata", {24'd0, P_DATA}, 32'd0);
    check("midreset_valid", {31'd0, data_valid}, 32'd0);
    model_pdata = '0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(4);
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized frames.
    for (int n = 0; n < 30; n++) begin
      int            p;
      int            kind;
      logic [DW-1:0] d;
      bit            pen;
      bit            ptype;
      p     = $urandom_range(4, 31);
      kind  = $urandom_range(0, 7);
      d     = DW'($urandom);
      pen   = 1'($urandom);
      ptype = 1'($urandom);
      if (kind == 2) begin
        glitch(p, $urandom_range(1, p / 2 - 1));
      end else if (kind == 1) begin
        send_frame(d, p, pen, ptype, 1'b0, 1'b0, 1'b1);
        idle($urandom_range(2, 6));
      end else begin
        send_frame(d, p, pen, ptype, kind == 0, 1'b1, 1'b1);
        idle($urandom_range(0, 3));
      end
    end

    begin
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
        @(posedge CLK);
        t++;
      end
      check("drain", exp_q.size(), 32'd0);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: UART_RX

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of data bits per frame and width of P_DATA.
REQ-002 Parameter PRESCALE_WIDTH, default 5: width of Prescale.
REQ-003 CLK  input  1  oversampling clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 RX_IN  input  1  serial line; idle high.
REQ-006 Prescale  input  PRESCALE_WIDTH  CLK cycles per bit; supported values 4..31, static during a frame.
REQ-007 parity_enable  input  1  1 = frame carries a parity bit.
REQ-008 parity_type  input  1  0 = even parity, 1 = odd parity.
REQ-009 P_DATA  output  DATA_WIDTH  last correctly received byte, registered.
REQ-010 data_valid  output  1  one-CLK pulse marking a new valid P_DATA.

Function
REQ-011 Frame format: start bit (0), DATA_WIDTH data bits LSB first, parity bit only if parity_enable=1, stop bit (1).
REQ-012 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-013 IDLE: RX_IN sampled 0 on a CLK edge -> START; that edge is edge count 0 of the start bit.
REQ-014 Edge counter runs 0..Prescale-1 per bit, then wraps to 0 and advances the bit counter.
REQ-015 Each bit value is the majority of 3 RX_IN samples taken at edge counts P/2-1, P/2, P/2+1 (P/2 = floor(Prescale/2)).
REQ-016 START: a sampled value of 1 (glitch) -> IDLE after the last sample edge, no output change; 0 -> DATA at end of bit.
REQ-017 DATA: each sampled bit shifts into the deserializer at bit position = bit index (LSB first); after DATA_WIDTH bits -> PARITY if parity_enable=1, else STOP.
REQ-018 PARITY: expected bit = XOR of data bits (even) or its inverse (odd); mismatch sets the parity-error flag; -> STOP at end of bit.
REQ-019 STOP: once the stop bit is sampled (edge P/2+1), evaluate and return to IDLE on the next edge; do not wait for the rest of the stop bit, so a start bit immediately following the stop bit is received.
REQ-020 Frame valid iff start sampled 0, no parity error (or parity disabled), stop sampled 1.
REQ-021 Valid frame: P_DATA <= deserialized byte and data_valid = 1 for exactly one CLK, in the cycle after the stop-bit decision.
REQ-022 Invalid frame: data_valid stays 0, P_DATA holds its previous value, FSM -> IDLE.
REQ-023 Stop error with RX_IN still low: IDLE re-arms only after RX_IN is sampled high (no false start from a held-low line).
REQ-024 parity_enable and parity_type are sampled when the frame starts (entry to START) and held for that frame.

Reset
REQ-025 RST high asynchronously forces FSM=IDLE, all counters and flags to 0, P_DATA=0, data_valid=0.
REQ-026 Reset mid-frame discards the partial frame; after release, reception restarts only on a new start bit.

Verification
REQ-027 Prescale=8, parity even, back-to-back frames at 8 CLK/bit: 0x55 (parity 0) then 0x7D (parity 0) -> two data_valid pulses, P_DATA=0x55 then 0x7D.
REQ-028 Prescale=8, even parity, frame 0x55 with parity bit 1 -> no data_valid, P_DATA unchanged; the next good frame 0xA5 -> P_DATA=0xA5 with a valid pulse.
REQ-029 Prescale=8, stop bit 0 on frame 0x3C -> no data_valid; after the line returns idle, frame 0x3C -> valid, P_DATA=0x3C.
REQ-030 RX_IN low for 2 CLK then high (Prescale=8) -> FSM returns to IDLE, no data_valid; a following frame 0x81 is received correctly.
REQ-031 Prescale=16, parity_enable=0: frame 0xA3 -> valid, P_DATA=0xA3; Prescale=8, odd parity, 0x01 with parity bit 0 -> valid, P_DATA=0x01.
REQ-032 RST asserted during data bit 4 of frame 0xFF -> outputs 0 immediately; after release, frame 0x12 -> P_DATA=0x12 with one valid pulse.
